// File: rtl/cpu_axi_bridge_mo_if.sv
// cpu_axi_bridge_mo_if: AXI3 bus between the CPU bridge (master) and the SoC crossbar (slave)
interface cpu_axi_bridge_mo_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [3:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic [1:0] arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic arvalid, arready;
  logic [3:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic [3:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic [1:0] awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic awvalid, awready;
  logic [3:0] wid;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input arready,
    input rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input wready,
    input bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input rready,
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input bready
  );
endinterface

// File: rtl/cpu_axi_bridge_mo.sv
// cpu_axi_bridge_mo: inst (read-only) and data (r/w) SRAM-like ports onto one AXI3 master with outstanding reads
module cpu_axi_bridge_mo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_OS = 2,
  parameter int INST_ID = 0,
  parameter int DATA_ID = 1
) (
  input logic clk,
  input logic resetn,
  input logic inst_req,
  input logic inst_wr,
  input logic [1:0] inst_size,
  input logic [ADDR_W-1:0] inst_addr,
  output logic inst_addr_ok,
  output logic inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input logic data_req,
  input logic data_wr,
  input logic [1:0] data_size,
  input logic [ADDR_W-1:0] data_addr,
  input logic [DATA_W-1:0] data_wdata,
  input logic [DATA_W/8-1:0] data_wstrb,
  output logic data_addr_ok,
  output logic data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  cpu_axi_bridge_mo_if.master axi
);
  localparam logic [3:0] OS = 4'(RD_OS);
  localparam logic [3:0] IID = 4'(INST_ID);
  localparam logic [3:0] DID = 4'(DATA_ID);
  logic inst_sv, data_sv, ar_busy, ar_own, rr_last, wr_busy, aw_pend, w_pend;
  logic [ADDR_W-1:0] inst_sa, data_sa, w_addr;
  logic [1:0] inst_ss, data_ss, w_size;
  logic [2:0] inst_cnt, data_cnt;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic data_rd_ok, data_wr_ok, ar_hs, inst_ar, data_ar, inst_rv, data_rv, b_ok, pick_data;
  logic unused_ok;
  // Writes wait for all data reads to drain so data_data_ok stays in request order
  always_comb begin
    inst_addr_ok = inst_req & !inst_sv & (({1'b0, inst_cnt} + {3'b0, inst_sv}) < OS);
    data_rd_ok = data_req & !data_wr & !data_sv & ({1'b0, data_cnt} < OS) & !wr_busy;
    data_wr_ok = data_req & data_wr & !wr_busy & !data_sv & (data_cnt == 3'd0);
    data_addr_ok = data_rd_ok | data_wr_ok;
    ar_hs = ar_busy & axi.arready;
    inst_ar = ar_hs & !ar_own;
    data_ar = ar_hs & ar_own;
    inst_rv = axi.rvalid & (axi.rid == IID) & (inst_cnt != 3'd0);
    data_rv = axi.rvalid & (axi.rid == DID) & (data_cnt != 3'd0);
    b_ok = axi.bvalid & wr_busy;
    inst_data_ok = inst_rv;
    inst_rdata = inst_rv ? axi.rdata : '0;
    data_data_ok = data_rv | b_ok;
    data_rdata = data_rv ? axi.rdata : '0;
    pick_data = data_sv & (!inst_sv | !rr_last);
  end
  assign unused_ok = ^{inst_wr, axi.rresp, axi.rlast, axi.bid, axi.bresp};
  assign axi.arid = ar_own ? DID : IID;
  assign axi.araddr = ar_own ? data_sa : inst_sa;
  assign axi.arsize = {1'b0, ar_own ? data_ss : inst_ss};
  assign axi.arlen = '0;
  assign axi.arburst = 2'b01;
  assign axi.arlock = '0;
  assign axi.arcache = '0;
  assign axi.arprot = '0;
  assign axi.arvalid = ar_busy;
  assign axi.rready = 1'b1;
  assign axi.awid = DID;
  assign axi.awaddr = w_addr;
  assign axi.awlen = '0;
  assign axi.awsize = {1'b0, w_size};
  assign axi.awburst = 2'b01;
  assign axi.awlock = '0;
  assign axi.awcache = '0;
  assign axi.awprot = '0;
  assign axi.awvalid = aw_pend;
  assign axi.wid = DID;
  assign axi.wdata = w_data;
  assign axi.wstrb = w_strb;
  assign axi.wlast = 1'b1;
  assign axi.wvalid = w_pend;
  assign axi.bready = 1'b1;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_sv <= 1'b0;
      data_sv <= 1'b0;
      ar_busy <= 1'b0;
      ar_own <= 1'b0;
      rr_last <= 1'b0;
      wr_busy <= 1'b0;
      aw_pend <= 1'b0;
      w_pend <= 1'b0;
      inst_cnt <= '0;
      data_cnt <= '0;
    end else begin
      if (inst_addr_ok) inst_sv <= 1'b1;
      else if (inst_ar) inst_sv <= 1'b0;
      if (data_rd_ok) data_sv <= 1'b1;
      else if (data_ar) data_sv <= 1'b0;
      inst_cnt <= inst_cnt + 3'(inst_ar) - 3'(inst_rv);
      data_cnt <= data_cnt + 3'(data_ar) - 3'(data_rv);
      if (ar_hs) begin
        ar_busy <= 1'b0;
        rr_last <= ar_own;
      end else if (!ar_busy && (inst_sv || data_sv)) begin
        ar_busy <= 1'b1;
        ar_own <= pick_data;
      end
      if (data_wr_ok) begin
        wr_busy <= 1'b1;
        aw_pend <= 1'b1;
        w_pend <= 1'b1;
      end else begin
        if (b_ok) wr_busy <= 1'b0;
        if (axi.awready) aw_pend <= 1'b0;
        if (axi.wready) w_pend <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (inst_addr_ok) begin
      inst_sa <= inst_addr;
      inst_ss <= inst_size;
    end
    if (data_rd_ok) begin
      data_sa <= data_addr;
      data_ss <= data_size;
    end
    if (data_wr_ok) begin
      w_addr <= data_addr;
      w_size <= data_size;
      w_data <= data_wdata;
      w_strb <= data_wstrb;
    end
  end
endmodule

// File: tb/tb_cpu_axi_bridge_mo.sv
// tb_cpu_axi_bridge_mo: directed scenarios for the multi-outstanding CPU to AXI bridge
module tb_cpu_axi_bridge_mo;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0] inst_size = 2'd2;
  logic [31:0] inst_addr = '0;
  logic inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic data_req = 1'b0, data_wr = 1'b0;
  logic [1:0] data_size = 2'd2;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [3:0] data_wstrb = '0;
  logic data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  int tests = 0, fails = 0;
  logic [31:0] ar_q[$];
  cpu_axi_bridge_mo_if axi();
  cpu_axi_bridge_mo dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .axi(axi)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (axi.arvalid && axi.arready) ar_q.push_back(axi.araddr);
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, want completion");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ar(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      if (axi.arvalid) seen = 1'b1;
      else cyc();
    end
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) cyc();
    tests++;
    if (axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valids: ar=%b aw=%b w=%b, want 0 0 0", axi.arvalid, axi.awvalid, axi.wvalid);
    end
    tests++;
    if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0) begin
      fails++;
      $display("FAIL reset_handshake: %b, want 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
    end
    tests++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: inst=%h data=%h, want 0 0", inst_rdata, data_rdata);
    end
    tests++;
    if (axi.arlen !== 8'd0 || axi.arburst !== 2'b01 || axi.awburst !== 2'b01 || axi.wlast !== 1'b1 ||
        axi.rready !== 1'b1 || axi.bready !== 1'b1 || axi.arprot !== 3'd0 || axi.awcache !== 4'd0) begin
      fails++;
      $display("FAIL const_outputs: arlen=%h arburst=%b awburst=%b wlast=%b rready=%b bready=%b, want 0 01 01 1 1 1",
               axi.arlen, axi.arburst, axi.awburst, axi.wlast, axi.rready, axi.bready);
    end
    resetn = 1'b1;
    cyc();
  endtask
  task automatic test_single_read();
    bit seen;
    inst_addr = 32'hBFC0_0000;
    inst_size = 2'd2;
    inst_req = 1'b1;
    #1;
    tests++;
    if (inst_addr_ok !== 1'b1 || axi.arvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_accept: addr_ok=%b arvalid=%b, want 1 0", inst_addr_ok, axi.arvalid);
    end
    cyc();
    inst_req = 1'b0;
    wait_ar(seen);
    tests++;
    if (!seen || axi.araddr !== 32'hBFC0_0000 || axi.arsize !== 3'd2 || axi.arid !== 4'd0) begin
      fails++;
      $display("FAIL single_ar: seen=%b araddr=%h arsize=%0d arid=%0d, want 1 bfc00000 2 0", seen, axi.araddr, axi.arsize, axi.arid);
    end
    cyc();
    tests++;
    if (axi.arvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_ar_drop: arvalid=%b, want 0", axi.arvalid);
    end
    cyc();
    axi.rvalid = 1'b1;
    axi.rid = 4'd0;
    axi.rdata = 32'h2408_0001;
    #1;
    tests++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h2408_0001 || data_data_ok !== 1'b0) begin
      fails++;
      $display("FAIL single_r: inst_data_ok=%b rdata=%h data_data_ok=%b, want 1 24080001 0", inst_data_ok, inst_rdata, data_data_ok);
    end
    cyc();
    axi.rvalid = 1'b0;
    #1;
    tests++;
    if (inst_data_ok !== 1'b0) begin
      fails++;
      $display("FAIL single_r_once: inst_data_ok=%b, want 0", inst_data_ok);
    end
  endtask
  task automatic test_outstanding();
    int hs0, acc;
    bit seen;
    hs0 = ar_q.size();
    acc = 0;
    inst_addr = 32'h0000_1000;
    inst_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (inst_addr_ok) acc++;
      cyc();
    end
    tests++;
    if (acc != 2 || ar_q.size() - hs0 != 2) begin
      fails++;
      $display("FAIL os_saturate: accepts=%0d ar_handshakes=%0d, want 2 2", acc, ar_q.size() - hs0);
    end
    axi.rvalid = 1'b1;
    axi.rid = 4'd0;
    axi.rdata = 32'h0000_1111;
    #1;
    tests++;
    if (inst_data_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
      fails++;
      $display("FAIL os_return_same_cycle: data_ok=%b addr_ok=%b, want 1 0", inst_data_ok, inst_addr_ok);
    end
    cyc();
    axi.rvalid = 1'b0;
    #1;
    tests++;
    if (inst_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL os_reaccept: addr_ok=%b, want 1", inst_addr_ok);
    end
    cyc();
    inst_req = 1'b0;
    wait_ar(seen);
    cyc();
    for (int k = 0; k < 2; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata = 32'h0000_2220 + k;
      #1;
      tests++;
      if (!seen || inst_data_ok !== 1'b1 || inst_rdata !== 32'h0000_2220 + k) begin
        fails++;
        $display("FAIL os_drain%0d: ar_seen=%b data_ok=%b rdata=%h, want 1 1 %h", k, seen, inst_data_ok, inst_rdata, 32'h0000_2220 + k);
      end
      cyc();
      axi.rvalid = 1'b0;
    end
  endtask
  task automatic test_rr();
    int ia, da, stall, q0;
    logic [31:0] held;
    ia = 0;
    da = 0;
    stall = 0;
    held = '0;
    q0 = ar_q.size();
    data_wr = 1'b0;
    data_size = 2'd2;
    for (int i = 0; i < 40 && ar_q.size() - q0 < 4; i++) begin
      inst_req = (ia < 2);
      inst_addr = (ia == 0) ? 32'h0000_0100 : 32'h0000_0104;
      data_req = (da < 2);
      data_addr = (da == 0) ? 32'h0000_0200 : 32'h0000_0204;
      axi.arready = (stall >= 3);
      #1;
      if (axi.arvalid && !axi.arready) begin
        if (stall == 0) held = axi.araddr;
        else begin
          tests++;
          if (axi.araddr !== held) begin
            fails++;
            $display("FAIL rr_stable: araddr=%h, want %h", axi.araddr, held);
          end
        end
        stall++;
      end
      if (inst_addr_ok) ia++;
      if (data_addr_ok) da++;
      cyc();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    axi.arready = 1'b1;
    tests++;
    if (ar_q.size() - q0 != 4 || ar_q[q0] !== 32'h200 || ar_q[q0+1] !== 32'h100 ||
        ar_q[q0+2] !== 32'h204 || ar_q[q0+3] !== 32'h104) begin
      fails++;
      $display("FAIL rr_order: n=%0d want order 200 100 204 104", ar_q.size() - q0);
    end
    for (int k = 0; k < 4; k++) begin
      axi.rvalid = 1'b1;
      axi.rid = (k < 2) ? 4'd1 : 4'd0;
      axi.rdata = 32'h0000_3300 + k;
      #1;
      tests++;
      if ((k < 2) ? (data_data_ok !== 1'b1 || data_rdata !== 32'h3300 + k || inst_data_ok !== 1'b0)
                  : (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3300 + k || data_data_ok !== 1'b0)) begin
        fails++;
        $display("FAIL rr_return%0d: inst_ok=%b data_ok=%b inst_rdata=%h data_rdata=%h, want rdata %h on %s",
                 k, inst_data_ok, data_data_ok, inst_rdata, data_rdata, 32'h3300 + k, (k < 2) ? "data" : "inst");
      end
      cyc();
      axi.rvalid = 1'b0;
    end
  endtask
  task automatic test_byte_store();
    bit seen;
    data_req = 1'b1;
    data_wr = 1'b1;
    data_addr = 32'h0000_1003;
    data_size = 2'd0;
    data_wstrb = 4'b1000;
    data_wdata = 32'h1100_0000;
    axi.awready = 1'b0;
    axi.wready = 1'b1;
    #1;
    tests++;
    if (data_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL store_accept: addr_ok=%b, want 1", data_addr_ok);
    end
    cyc();
    data_wr = 1'b0;
    data_addr = 32'h0000_2000;
    data_size = 2'd2;
    #1;
    tests++;
    if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.awsize !== 3'd0 || axi.awaddr !== 32'h1003 ||
        axi.wstrb !== 4'b1000 || axi.wdata !== 32'h1100_0000 || axi.awid !== 4'd1 || axi.wid !== 4'd1) begin
      fails++;
      $display("FAIL store_aw_w: awv=%b wv=%b awsize=%0d awaddr=%h wstrb=%b wdata=%h, want 1 1 0 1003 1000 11000000",
               axi.awvalid, axi.wvalid, axi.awsize, axi.awaddr, axi.wstrb, axi.wdata);
    end
    tests++;
    if (data_addr_ok !== 1'b0) begin
      fails++;
      $display("FAIL store_block_rd0: addr_ok=%b, want 0", data_addr_ok);
    end
    cyc();
    #1;
    tests++;
    if (axi.wvalid !== 1'b0 || axi.awvalid !== 1'b1 || data_addr_ok !== 1'b0 || data_data_ok !== 1'b0) begin
      fails++;
      $display("FAIL store_w_first: wv=%b awv=%b addr_ok=%b data_ok=%b, want 0 1 0 0", axi.wvalid, axi.awvalid, data_addr_ok, data_data_ok);
    end
    cyc();
    axi.awready = 1'b1;
    #1;
    tests++;
    if (axi.awvalid !== 1'b1) begin
      fails++;
      $display("FAIL store_aw_hold: awvalid=%b, want 1", axi.awvalid);
    end
    cyc();
    #1;
    tests++;
    if (axi.awvalid !== 1'b0 || data_data_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
      fails++;
      $display("FAIL store_aw_done: awv=%b data_ok=%b addr_ok=%b, want 0 0 0", axi.awvalid, data_data_ok, data_addr_ok);
    end
    axi.bvalid = 1'b1;
    axi.rdata = 32'hFFFF_FFFF;
    #1;
    tests++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h0 || data_addr_ok !== 1'b0) begin
      fails++;
      $display("FAIL store_b: data_ok=%b rdata=%h addr_ok=%b, want 1 0 0", data_data_ok, data_rdata, data_addr_ok);
    end
    cyc();
    axi.bvalid = 1'b0;
    #1;
    tests++;
    if (data_data_ok !== 1'b0 || data_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL store_after_b: data_ok=%b addr_ok=%b, want 0 1", data_data_ok, data_addr_ok);
    end
    cyc();
    data_req = 1'b0;
    wait_ar(seen);
    tests++;
    if (!seen || axi.araddr !== 32'h2000 || axi.arid !== 4'd1 || axi.arsize !== 3'd2) begin
      fails++;
      $display("FAIL store_then_rd_ar: seen=%b araddr=%h arid=%0d, want 1 2000 1", seen, axi.araddr, axi.arid);
    end
    cyc();
    axi.rvalid = 1'b1;
    axi.rid = 4'd1;
    axi.rdata = 32'h0000_0055;
    #1;
    tests++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'h55) begin
      fails++;
      $display("FAIL store_then_rd_r: data_ok=%b rdata=%h, want 1 55", data_data_ok, data_rdata);
    end
    cyc();
    axi.rvalid = 1'b0;
  endtask
  task automatic test_wr_after_rd();
    bit seen;
    axi.awready = 1'b1;
    axi.wready = 1'b1;
    data_req = 1'b1;
    data_wr = 1'b0;
    data_addr = 32'h0000_3000;
    #1;
    tests++;
    if (data_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL war_rd_accept: addr_ok=%b, want 1", data_addr_ok);
    end
    cyc();
    data_wr = 1'b1;
    data_addr = 32'h0000_4000;
    data_wdata = 32'hA5A5_5A5A;
    data_wstrb = 4'hF;
    wait_ar(seen);
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (!seen || data_addr_ok !== 1'b0) begin
        fails++;
        $display("FAIL war_block%0d: ar_seen=%b addr_ok=%b, want 1 0", k, seen, data_addr_ok);
      end
      cyc();
    end
    axi.rvalid = 1'b1;
    axi.rid = 4'd1;
    axi.rdata = 32'hCAFE_0001;
    #1;
    tests++;
    if (data_data_ok !== 1'b1 || data_rdata !== 32'hCAFE_0001 || data_addr_ok !== 1'b0) begin
      fails++;
      $display("FAIL war_r: data_ok=%b rdata=%h addr_ok=%b, want 1 cafe0001 0", data_data_ok, data_rdata, data_addr_ok);
    end
    cyc();
    axi.rvalid = 1'b0;
    #1;
    tests++;
    if (data_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL war_wr_accept: addr_ok=%b, want 1", data_addr_ok);
    end
    cyc();
    data_req = 1'b0;
    #1;
    tests++;
    if (axi.awvalid !== 1'b1 || axi.wvalid !== 1'b1 || axi.awaddr !== 32'h4000 || axi.wdata !== 32'hA5A5_5A5A || axi.awsize !== 3'd2) begin
      fails++;
      $display("FAIL war_aw_w: awv=%b wv=%b awaddr=%h wdata=%h awsize=%0d, want 1 1 4000 a5a55a5a 2",
               axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.awsize);
    end
    cyc();
    #1;
    tests++;
    if (axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
      fails++;
      $display("FAIL war_aw_w_done: awv=%b wv=%b, want 0 0", axi.awvalid, axi.wvalid);
    end
    axi.bvalid = 1'b1;
    #1;
    tests++;
    if (data_data_ok !== 1'b1) begin
      fails++;
      $display("FAIL war_b: data_ok=%b, want 1", data_data_ok);
    end
    cyc();
    axi.bvalid = 1'b0;
  endtask
  task automatic test_reset_mid();
    bit seen;
    inst_addr = 32'h0000_5000;
    inst_req = 1'b1;
    #1;
    cyc();
    inst_req = 1'b0;
    wait_ar(seen);
    cyc();
    resetn = 1'b0;
    cyc();
    cyc();
    tests++;
    if (!seen || axi.arvalid !== 1'b0 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_valids: ar_seen=%b ar=%b aw=%b w=%b, want 1 0 0 0", seen, axi.arvalid, axi.awvalid, axi.wvalid);
    end
    resetn = 1'b1;
    cyc();
    axi.rvalid = 1'b1;
    axi.rid = 4'd0;
    axi.rdata = 32'hDEAD_BEEF;
    #1;
    tests++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h0 || data_data_ok !== 1'b0) begin
      fails++;
      $display("FAIL midreset_stale: inst_ok=%b rdata=%h data_ok=%b, want 0 0 0", inst_data_ok, inst_rdata, data_data_ok);
    end
    cyc();
    axi.rvalid = 1'b0;
    inst_req = 1'b1;
    #1;
    tests++;
    if (inst_addr_ok !== 1'b1) begin
      fails++;
      $display("FAIL midreset_cnt: addr_ok=%b, want 1", inst_addr_ok);
    end
    cyc();
    inst_req = 1'b0;
  endtask
  initial begin
    axi.arready = 1'b1;
    axi.rid = '0;
    axi.rdata = '0;
    axi.rresp = '0;
    axi.rlast = 1'b1;
    axi.rvalid = 1'b0;
    axi.awready = 1'b1;
    axi.wready = 1'b1;
    axi.bid = 4'd1;
    axi.bresp = '0;
    axi.bvalid = 1'b0;
    test_reset();
    test_single_read();
    test_outstanding();
    test_rr();
    test_byte_store();
    test_wr_after_rd();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
